dvs_event_fifo: RTL and testbench



---
 rtl/dvs_event_fifo.sv | 103 ++++++++++
 tb/tb_dvs_event_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_event_fifo.sv
// rtl/dvs_event_fifo.sv - first-word-fall-through FIFO buffering DVS address events with drop accounting

package dvs_ravens_pkg;
   localparam int DVS_X_ADDR_BITS   = 8;
   localparam int DVS_Y_ADDR_BITS   = 8;
   localparam int TIMESTAMP_US_BITS = 32;
   localparam int CLK_PERIOD_NS     = 10;
endpackage

module dvs_event_fifo
   import dvs_ravens_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int DROP_CNT_BITS = 16,
   localparam int EVENT_BITS   = TIMESTAMP_US_BITS + DVS_Y_ADDR_BITS + DVS_X_ADDR_BITS + 1,
   localparam int LEVEL_BITS   = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DVS_X_ADDR_BITS-1:0]   event_x,
   input  logic [DVS_Y_ADDR_BITS-1:0]   event_y,
   input  logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
   input  logic                         event_polarity,
   input  logic                         new_event,
   output logic [EVENT_BITS-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LEVEL_BITS-1:0]        fill_level,
   output logic                         overflow,
   input  logic                         clr_overflow,
   output logic [DROP_CNT_BITS-1:0]     drop_count
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam logic [LEVEL_BITS-1:0]    LEVEL_FULL = LEVEL_BITS'(FIFO_DEPTH);
   localparam logic [DROP_CNT_BITS-1:0] DROP_MAX   = '1;

   logic [EVENT_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr;
   logic [PTR_BITS-1:0]   rd_ptr;
   logic [EVENT_BITS-1:0] event_packed;
   logic                  full;
   logic                  do_read;
   logic                  do_write;
   logic                  do_drop;

   // Full/empty come from the level counter so pointer equality is never ambiguous.
   assign full         = (fill_level == LEVEL_FULL);
   assign out_valid    = (fill_level != '0);
   assign do_read      = out_valid & out_ready;
   // A read in the same edge frees a slot, so a full FIFO still accepts the write.
   assign do_write     = new_event & (~full | do_read);
   assign do_drop      = new_event & full & ~do_read;
   assign event_packed = {event_timestamp, event_y, event_x, event_polarity};
   assign out_data     = mem[rd_ptr];

   // Event storage; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= event_packed;
      end
   end

   // Pointers and level; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         if (do_write && !do_read) begin
            fill_level <= fill_level + LEVEL_BITS'(1);
         end else if (do_read && !do_write) begin
            fill_level <= fill_level - LEVEL_BITS'(1);
         end
      end
   end

   // Drop accounting; a drop coinciding with a clear restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (do_drop) begin
         overflow <= 1'b1;
         if (clr_overflow) begin
            drop_count <= DROP_CNT_BITS'(1);
         end else if (drop_count != DROP_MAX) begin
            drop_count <= drop_count + DROP_CNT_BITS'(1);
         end
      end else if (clr_overflow) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_dvs_event_fifo.sv
// tb/tb_dvs_event_fifo.sv - randomized queue-model bench for dvs_event_fifo

module tb_dvs_event_fifo;
   import dvs_ravens_pkg::*;

   localparam int DEPTH    = 16;
   localparam int DCB      = 3;
   localparam int DROP_MAX = (1 << DCB) - 1;
   localparam int EB       = TIMESTAMP_US_BITS + DVS_Y_ADDR_BITS + DVS_X_ADDR_BITS + 1;
   localparam int LB       = $clog2(DEPTH) + 1;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic [DVS_X_ADDR_BITS-1:0]   event_x = '0;
   logic [DVS_Y_ADDR_BITS-1:0]   event_y = '0;
   logic [TIMESTAMP_US_BITS-1:0] event_timestamp = '0;
   logic                         event_polarity = 1'b0;
   logic                         new_event = 1'b0;
   logic [EB-1:0]                out_data;
   logic                         out_valid;
   logic                         out_ready = 1'b0;
   logic [LB-1:0]                fill_level;
   logic                         overflow;
   logic                         clr_overflow = 1'b0;
   logic [DCB-1:0]               drop_count;

   dvs_event_fifo #(.FIFO_DEPTH(DEPTH), .DROP_CNT_BITS(DCB)) dut (
      .clk(clk), .rst(rst), .event_x(event_x), .event_y(event_y),
      .event_timestamp(event_timestamp), .event_polarity(event_polarity),
      .new_event(new_event), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .fill_level(fill_level), .overflow(overflow),
      .clr_overflow(clr_overflow), .drop_count(drop_count)
   );

   always #(CLK_PERIOD_NS / 2) clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            popped = 0;
   logic [EB-1:0] m_q[$];
   bit            m_ovf = 0;
   int            m_drop = 0;

   function automatic logic [EB-1:0] cur_event();
      return {event_timestamp, event_y, event_x, event_polarity};
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_ovf  = 0;
      m_drop = 0;
   endtask

   task automatic rand_event();
      event_x         = DVS_X_ADDR_BITS'($urandom);
      event_y         = DVS_Y_ADDR_BITS'($urandom);
      event_timestamp = TIMESTAMP_US_BITS'($urandom);
      event_polarity  = 1'($urandom);
   endtask

   // One clock edge; the reference queue follows the FIFO rules, then outputs settle for sampling.
   task automatic cycle();
      bit rd, drop;
      logic [EB-1:0] ev;
      rd   = (m_q.size() != 0) && out_ready;
      drop = new_event && (m_q.size() == DEPTH) && !rd;
      ev   = cur_event();
      @(posedge clk);
      if (rd) begin
         m_q.delete(0);
         popped++;
      end
      if (new_event && !drop) m_q.push_back(ev);
      if (drop) begin
         m_ovf  = 1;
         m_drop = clr_overflow ? 1 : ((m_drop == DROP_MAX) ? DROP_MAX : m_drop + 1);
      end else if (clr_overflow) begin
         m_ovf  = 0;
         m_drop = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || fill_level !== '0 || overflow !== 1'b0 || drop_count !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b fill=%0d ovf=%b drops=%0d, want 0 0 0 0",
                  out_valid, fill_level, overflow, drop_count);
      end
      #10 rst = 1'b0;
      model_clear();
   endtask

   task automatic test_single_event();
      logic [EB-1:0] exp;
      event_x = 8'd5; event_y = 8'd7; event_timestamp = 32'd1000; event_polarity = 1'b1;
      exp = {32'd1000, 8'd7, 8'd5, 1'b1};
      new_event = 1'b1; out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_no_bypass: valid=%b want 0", out_valid);
      end
      cycle();
      new_event = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || fill_level !== LB'(1)) begin
         errors++;
         $display("FAIL single_event: valid=%b data=%h fill=%0d want 1 %h 1",
                  out_valid, out_data, fill_level, exp);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || fill_level !== '0) begin
         errors++;
         $display("FAIL single_drain: valid=%b fill=%0d want 0 0", out_valid, fill_level);
      end
   endtask

   task automatic test_burst_fill();
      logic [EB-1:0] sent[17];
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         rand_event();
         sent[i] = cur_event();
         new_event = 1'b1;
         cycle();
      end
      new_event = 1'b0;
      checks++;
      if (fill_level !== LB'(DEPTH) || overflow !== 1'b1 || drop_count !== DCB'(1)) begin
         errors++;
         $display("FAIL burst_full: fill=%0d ovf=%b drops=%0d want 16 1 1",
                  fill_level, overflow, drop_count);
      end
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== sent[i]) begin
            errors++;
            $display("FAIL burst_order[%0d]: valid=%b data=%h want 1 %h", i, out_valid, out_data, sent[i]);
         end
         cycle();
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || m_q.size() != 0) begin
         errors++;
         $display("FAIL burst_empty: valid=%b model=%0d want 0 0", out_valid, m_q.size());
      end
   endtask

   task automatic test_full_simultaneous();
      logic [EB-1:0] last;
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rand_event();
         new_event = 1'b1;
         cycle();
      end
      rand_event();
      last = cur_event();
      out_ready = 1'b1;
      cycle();
      new_event = 1'b0;
      checks++;
      if (fill_level !== LB'(DEPTH) || drop_count !== DCB'(1) || overflow !== 1'b1) begin
         errors++;
         $display("FAIL full_simul: fill=%0d drops=%0d ovf=%b want 16 1 1", fill_level, drop_count, overflow);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         checks++;
         if (out_data !== m_q[0]) begin
            errors++;
            $display("FAIL full_simul_drain[%0d]: data=%h want %h", i, out_data, m_q[0]);
         end
         cycle();
      end
      checks++;
      if (out_valid !== 1'b1 || fill_level !== LB'(1) || out_data !== last) begin
         errors++;
         $display("FAIL full_simul_last: valid=%b fill=%0d data=%h want 1 1 %h",
                  out_valid, fill_level, out_data, last);
      end
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_clear_vs_drop();
      clr_overflow = 1'b1;
      cycle();
      clr_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b0 || drop_count !== '0) begin
         errors++;
         $display("FAIL clear: ovf=%b drops=%0d want 0 0", overflow, drop_count);
      end
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         rand_event();
         new_event = 1'b1;
         cycle();
      end
      checks++;
      if (drop_count !== DCB'(3) || overflow !== 1'b1) begin
         errors++;
         $display("FAIL three_drops: drops=%0d ovf=%b want 3 1", drop_count, overflow);
      end
      clr_overflow = 1'b1;
      cycle();
      clr_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b1 || drop_count !== DCB'(1)) begin
         errors++;
         $display("FAIL clear_vs_drop: ovf=%b drops=%0d want 1 1", overflow, drop_count);
      end
      for (int i = 0; i < 10; i++) cycle();
      new_event = 1'b0;
      checks++;
      if (drop_count !== DCB'(DROP_MAX) || drop_count !== DCB'(m_drop)) begin
         errors++;
         $display("FAIL drop_saturate: drops=%0d want %0d", drop_count, DROP_MAX);
      end
   endtask

   task automatic test_reset_mid();
      logic [EB-1:0] first;
      rst = 1'b1;
      #1 rst = 1'b0;
      model_clear();
      cycle();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_event();
         new_event = 1'b1;
         cycle();
      end
      new_event = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      model_clear();
      checks++;
      if (out_valid !== 1'b0 || fill_level !== '0 || overflow !== 1'b0 || drop_count !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b fill=%0d ovf=%b drops=%0d want 0 0 0 0",
                  out_valid, fill_level, overflow, drop_count);
      end
      #1 rst = 1'b0;
      rand_event();
      first = cur_event();
      new_event = 1'b1;
      cycle();
      new_event = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || fill_level !== LB'(1) || out_data !== first) begin
         errors++;
         $display("FAIL post_reset_first: valid=%b fill=%0d data=%h want 1 1 %h",
                  out_valid, fill_level, out_data, first);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_streaming();
      int bad = 0;
      out_ready = 1'b1;
      popped = 0;
      for (int i = 0; i < 2000; i++) begin
         new_event = (i % 2 == 0);
         if (new_event) rand_event();
         cycle();
         if (fill_level > LB'(1) || out_valid !== (m_q.size() != 0) ||
             (out_valid === 1'b1 && m_q.size() != 0 && out_data !== m_q[0])) begin
            bad++;
            if (bad < 5)
               $display("FAIL stream[%0d]: valid=%b fill=%0d data=%h want fill<=1 model=%0d",
                        i, out_valid, fill_level, out_data, m_q.size());
         end
      end
      new_event = 1'b0;
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (popped != 1000 || overflow !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_total: popped=%0d ovf=%b valid=%b want 1000 0 0", popped, overflow, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random_mix();
      for (int i = 0; i < 600; i++) begin
         new_event    = ($urandom_range(0, 99) < 60);
         out_ready    = ($urandom_range(0, 99) < 45);
         clr_overflow = ($urandom_range(0, 99) < 4);
         rand_event();
         cycle();
         checks++;
         if (fill_level !== LB'(m_q.size()) || out_valid !== (m_q.size() != 0) ||
             overflow !== m_ovf || drop_count !== DCB'(m_drop) ||
             (m_q.size() != 0 && out_data !== m_q[0])) begin
            errors++;
            $display("FAIL random[%0d]: fill=%0d/%0d ovf=%b/%b drops=%0d/%0d data=%h",
                     i, fill_level, m_q.size(), overflow, m_ovf, drop_count, m_drop, out_data);
         end
      end
      new_event = 1'b0;
      out_ready = 1'b0;
      clr_overflow = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_burst_fill();
      test_full_simultaneous();
      test_clear_vs_drop();
      test_reset_mid();
      test_streaming();
      test_random_mix();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
